// File: rtl/doorlock_pkg.sv
// doorlock_pkg: shared door-lock datapath constants, keypad codes and entry-buffer types
package doorlock_pkg;
  localparam int DIGIT_W = 4;
  localparam int PW_LEN = 4;
  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_BACK = 4'hB;
  typedef enum logic [2:0] {CMD_NONE, CMD_CLEAR, CMD_REPLACE, CMD_BACK, CMD_PUSH, CMD_REJECT} cmd_e;
  typedef enum logic [2:0] {SEL_HOLD, SEL_SHL, SEL_SHR, SEL_DIN, SEL_ZERO} sel_e;
endpackage

// File: rtl/digit_reg.sv
// digit_reg: one digit slot with load enable and synchronous reset
module digit_reg import doorlock_pkg::*; #(
  parameter int WIDTH = DIGIT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  // reset wins over enable; otherwise load when enabled
  always_ff @(posedge clock) q_o <= reset ? '0 : ce_i ? d_i : q_o;
endmodule

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: keypad digit buffer with push, backspace, replace, clear and overflow tracking
module digit_entry_buffer import doorlock_pkg::*; #(
  parameter int WIDTH = DIGIT_W,
  parameter int DEPTH = PW_LEN,
  parameter bit SHIFT_ON_FULL = 1'b0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   Ce,
  input  logic [WIDTH-1:0]       Din,
  input  logic                   push,
  input  logic                   back,
  input  logic                   clear,
  output logic [WIDTH*DEPTH-1:0] Dout,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic [WIDTH*DEPTH-1:0] shl, shr;
  cmd_e cmd;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign overflow = overflow_q;
  assign shl = Dout << WIDTH;
  assign shr = Dout >> WIDTH;
  // priority decode; replace on an empty buffer degrades to a push, back on empty is a no-op
  always_comb begin
    cmd = !Ce ? CMD_NONE
        : clear ? CMD_CLEAR
        : (push && back && !empty) ? CMD_REPLACE
        : (back && !push) ? (empty ? CMD_NONE : CMD_BACK)
        : push ? ((full && !SHIFT_ON_FULL) ? CMD_REJECT : CMD_PUSH)
        : CMD_NONE;
  end
  // fill count and sticky overflow; a push while full either rejects or drops the oldest digit
  always_comb begin
    count_d = cmd == CMD_CLEAR ? '0
            : cmd == CMD_BACK ? count_q - CW'(1)
            : (cmd == CMD_PUSH && !full) ? count_q + CW'(1)
            : count_q;
    overflow_d = cmd == CMD_CLEAR ? 1'b0
               : overflow_q || cmd == CMD_REJECT || (cmd == CMD_PUSH && full);
  end
  // registered count and overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    sel_e sel;
    logic [WIDTH-1:0] d;
    // per-slot source select: slot 0 takes Din on push/replace, others shift with the buffer
    always_comb begin
      sel = cmd == CMD_CLEAR ? SEL_ZERO
          : cmd == CMD_BACK ? SEL_SHR
          : ((cmd == CMD_PUSH || cmd == CMD_REPLACE) && i == 0) ? SEL_DIN
          : cmd == CMD_PUSH ? SEL_SHL
          : SEL_HOLD;
      d = sel == SEL_ZERO ? '0
        : sel == SEL_DIN ? Din
        : sel == SEL_SHL ? shl[i*WIDTH +: WIDTH]
        : sel == SEL_SHR ? shr[i*WIDTH +: WIDTH]
        : Dout[i*WIDTH +: WIDTH];
    end
    digit_reg #(.WIDTH(WIDTH)) u_reg (
      .clock(clock),
      .reset(reset),
      .ce_i(sel != SEL_HOLD),
      .d_i(d),
      .q_o(Dout[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb_digit_entry_buffer: four buffer configurations driven in lockstep against a queue-based model
module tb_digit_entry_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ce, push, back, clr;
  logic [3:0] din;
  logic [15:0] d0, d1;
  logic [3:0] d2, d3;
  logic [2:0] c0, c1;
  logic [0:0] c2, c3;
  logic [15:0] dout_a [4];
  int cnt_a [4];
  logic full_a [4], empty_a [4], ov_a [4];
  int errors = 0, checks = 0;
  localparam int DEP [4] = '{4, 4, 1, 1};
  localparam bit SHF [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] mq [4][$];
  bit mov [4];

  digit_entry_buffer #(.WIDTH(4), .DEPTH(4), .SHIFT_ON_FULL(1'b0)) u0 (.clock(clk), .reset(rst), .Ce(ce), .Din(din), .push(push), .back(back), .clear(clr), .Dout(d0), .count(c0), .full(full_a[0]), .empty(empty_a[0]), .overflow(ov_a[0]));
  digit_entry_buffer #(.WIDTH(4), .DEPTH(4), .SHIFT_ON_FULL(1'b1)) u1 (.clock(clk), .reset(rst), .Ce(ce), .Din(din), .push(push), .back(back), .clear(clr), .Dout(d1), .count(c1), .full(full_a[1]), .empty(empty_a[1]), .overflow(ov_a[1]));
  digit_entry_buffer #(.WIDTH(4), .DEPTH(1), .SHIFT_ON_FULL(1'b0)) u2 (.clock(clk), .reset(rst), .Ce(ce), .Din(din), .push(push), .back(back), .clear(clr), .Dout(d2), .count(c2), .full(full_a[2]), .empty(empty_a[2]), .overflow(ov_a[2]));
  digit_entry_buffer #(.WIDTH(4), .DEPTH(1), .SHIFT_ON_FULL(1'b1)) u3 (.clock(clk), .reset(rst), .Ce(ce), .Din(din), .push(push), .back(back), .clear(clr), .Dout(d3), .count(c3), .full(full_a[3]), .empty(empty_a[3]), .overflow(ov_a[3]));

  assign dout_a[0] = d0;
  assign dout_a[1] = d1;
  assign dout_a[2] = {12'h000, d2};
  assign dout_a[3] = {12'h000, d3};
  assign cnt_a[0] = 32'(c0);
  assign cnt_a[1] = 32'(c1);
  assign cnt_a[2] = 32'(c2);
  assign cnt_a[3] = 32'(c3);

  // model: queue holds digits oldest-first; newest is the back of the queue
  task automatic cycle(input logic r, input logic c, input logic p, input logic b, input logic cl, input logic [3:0] d);
    rst = r; ce = c; push = p; back = b; clr = cl; din = d;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (r || (c && cl)) begin
        mq[k].delete();
        mov[k] = 1'b0;
      end else if (c) begin
        if (p && b && mq[k].size() > 0) mq[k][mq[k].size()-1] = d;
        else if (b && !p) begin
          if (mq[k].size() > 0) void'(mq[k].pop_back());
        end else if (p) begin
          if (mq[k].size() < DEP[k]) mq[k].push_back(d);
          else begin
            mov[k] = 1'b1;
            if (SHF[k]) begin
              void'(mq[k].pop_front());
              mq[k].push_back(d);
            end
          end
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_dout(input int k);
    logic [15:0] v;
    int n;
    v = '0;
    n = mq[k].size();
    for (int j = 0; j < n; j++) v[j*4 +: 4] = mq[k][n-1-j];
    return v;
  endfunction

  task automatic test_reset();
    cycle(1, 0, 1, 0, 0, 4'h9);
    for (int k = 0; k < 4; k++) begin
      checks++; if (dout_a[k] !== 16'h0) begin errors++; $display("FAIL reset_dout inst%0d got %h exp 0000", k, dout_a[k]); end
      checks++; if (cnt_a[k] !== 0) begin errors++; $display("FAIL reset_count inst%0d got %0d exp 0", k, cnt_a[k]); end
      checks++; if (empty_a[k] !== 1'b1 || full_a[k] !== 1'b0) begin errors++; $display("FAIL reset_flags inst%0d empty %b full %b exp 1 0", k, empty_a[k], full_a[k]); end
      checks++; if (ov_a[k] !== 1'b0) begin errors++; $display("FAIL reset_ovf inst%0d got %b exp 0", k, ov_a[k]); end
    end
  endtask

  task automatic test_fill();
    for (int v = 1; v <= 4; v++) cycle(0, 1, 1, 0, 0, 4'(v));
    checks++; if (dout_a[0] !== 16'h1234) begin errors++; $display("FAIL fill_dout got %h exp 1234", dout_a[0]); end
    checks++; if (cnt_a[0] !== 4 || full_a[0] !== 1'b1) begin errors++; $display("FAIL fill_count got %0d full %b exp 4 1", cnt_a[0], full_a[0]); end
    checks++; if (ov_a[0] !== 1'b0) begin errors++; $display("FAIL fill_ovf got %b exp 0", ov_a[0]); end
    checks++; if (dout_a[2] !== 16'h1 || ov_a[2] !== 1'b1) begin errors++; $display("FAIL fill_d1_reject got %h ovf %b exp 0001 1", dout_a[2], ov_a[2]); end
    checks++; if (dout_a[3] !== 16'h4 || ov_a[3] !== 1'b1) begin errors++; $display("FAIL fill_d1_shift got %h ovf %b exp 0004 1", dout_a[3], ov_a[3]); end
  endtask

  task automatic test_push_full();
    cycle(0, 1, 1, 0, 0, 4'h5);
    checks++; if (dout_a[0] !== 16'h1234 || ov_a[0] !== 1'b1) begin errors++; $display("FAIL full_reject got %h ovf %b exp 1234 1", dout_a[0], ov_a[0]); end
    checks++; if (dout_a[1] !== 16'h2345 || ov_a[1] !== 1'b1) begin errors++; $display("FAIL full_shift got %h ovf %b exp 2345 1", dout_a[1], ov_a[1]); end
    checks++; if (cnt_a[1] !== 4 || cnt_a[0] !== 4) begin errors++; $display("FAIL full_count got %0d %0d exp 4 4", cnt_a[0], cnt_a[1]); end
  endtask

  task automatic test_back();
    cycle(1, 1, 0, 0, 0, 4'h0);
    for (int v = 1; v <= 3; v++) cycle(0, 1, 1, 0, 0, 4'(v));
    checks++; if (dout_a[0] !== 16'h0123 || cnt_a[0] !== 3) begin errors++; $display("FAIL back_pre got %h cnt %0d exp 0123 3", dout_a[0], cnt_a[0]); end
    cycle(0, 1, 0, 1, 0, 4'hF);
    checks++; if (dout_a[0] !== 16'h0012 || cnt_a[0] !== 2) begin errors++; $display("FAIL back_one got %h cnt %0d exp 0012 2", dout_a[0], cnt_a[0]); end
    for (int n = 0; n < 3; n++) cycle(0, 1, 0, 1, 0, 4'hF);
    checks++; if (dout_a[0] !== 16'h0 || cnt_a[0] !== 0 || empty_a[0] !== 1'b1) begin errors++; $display("FAIL back_empty got %h cnt %0d empty %b exp 0000 0 1", dout_a[0], cnt_a[0], empty_a[0]); end
    checks++; if (ov_a[0] !== 1'b0) begin errors++; $display("FAIL back_ovf got %b exp 0", ov_a[0]); end
  endtask

  task automatic test_replace();
    cycle(0, 1, 1, 0, 0, 4'h1);
    cycle(0, 1, 1, 0, 0, 4'h2);
    cycle(0, 1, 1, 1, 0, 4'h9);
    checks++; if (dout_a[0] !== 16'h0019 || cnt_a[0] !== 2) begin errors++; $display("FAIL replace got %h cnt %0d exp 0019 2", dout_a[0], cnt_a[0]); end
    checks++; if (dout_a[2] !== 16'h9 || ov_a[2] !== 1'b1) begin errors++; $display("FAIL replace_d1 got %h ovf %b exp 0009 1", dout_a[2], ov_a[2]); end
    cycle(0, 1, 0, 0, 1, 4'h0);
    cycle(0, 1, 1, 1, 0, 4'h7);
    checks++; if (dout_a[0] !== 16'h0007 || cnt_a[0] !== 1) begin errors++; $display("FAIL replace_empty got %h cnt %0d exp 0007 1", dout_a[0], cnt_a[0]); end
  endtask

  task automatic test_clear_all();
    for (int v = 0; v < 5; v++) cycle(0, 1, 1, 0, 0, 4'(v + 3));
    checks++; if (ov_a[0] !== 1'b1) begin errors++; $display("FAIL clear_pre_ovf got %b exp 1", ov_a[0]); end
    cycle(0, 1, 1, 1, 1, 4'hE);
    for (int k = 0; k < 4; k++) begin
      checks++; if (dout_a[k] !== 16'h0 || cnt_a[k] !== 0 || ov_a[k] !== 1'b0) begin errors++; $display("FAIL clear_all inst%0d got %h cnt %0d ovf %b exp 0000 0 0", k, dout_a[k], cnt_a[k], ov_a[k]); end
    end
    cycle(0, 0, 1, 0, 0, 4'h3);
    checks++; if (dout_a[0] !== 16'h0 || cnt_a[0] !== 0) begin errors++; $display("FAIL ce_low got %h cnt %0d exp 0000 0", dout_a[0], cnt_a[0]); end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, 1, 0, 0, 4'h1);
    cycle(0, 1, 1, 0, 0, 4'h2);
    checks++; if (cnt_a[0] !== 2) begin errors++; $display("FAIL mid_pre got %0d exp 2", cnt_a[0]); end
    cycle(1, 1, 1, 0, 0, 4'h5);
    for (int k = 0; k < 4; k++) begin
      checks++; if (dout_a[k] !== 16'h0 || cnt_a[k] !== 0 || empty_a[k] !== 1'b1 || ov_a[k] !== 1'b0) begin errors++; $display("FAIL mid_reset inst%0d got %h cnt %0d empty %b ovf %b", k, dout_a[k], cnt_a[k], empty_a[k], ov_a[k]); end
    end
  endtask

  task automatic test_depth1();
    cycle(0, 1, 1, 0, 0, 4'h4);
    cycle(0, 1, 1, 0, 0, 4'h6);
    checks++; if (dout_a[2] !== 16'h4 || ov_a[2] !== 1'b1 || full_a[2] !== 1'b1) begin errors++; $display("FAIL d1_reject got %h ovf %b full %b exp 0004 1 1", dout_a[2], ov_a[2], full_a[2]); end
    checks++; if (dout_a[3] !== 16'h6 || ov_a[3] !== 1'b1 || cnt_a[3] !== 1) begin errors++; $display("FAIL d1_shift got %h ovf %b cnt %0d exp 0006 1 1", dout_a[3], ov_a[3], cnt_a[3]); end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(63) == 0, $urandom_range(99) < 85, $urandom_range(1) == 1,
            $urandom_range(3) == 0, $urandom_range(15) == 0, 4'($urandom));
      for (int k = 0; k < 4; k++) begin
        n = mq[k].size();
        checks++; if (dout_a[k] !== exp_dout(k)) begin errors++; $display("FAIL rand_dout inst%0d cyc%0d got %h exp %h", k, i, dout_a[k], exp_dout(k)); end
        checks++; if (cnt_a[k] !== n) begin errors++; $display("FAIL rand_count inst%0d cyc%0d got %0d exp %0d", k, i, cnt_a[k], n); end
        checks++; if (full_a[k] !== (n == DEP[k])) begin errors++; $display("FAIL rand_full inst%0d cyc%0d got %b exp %b", k, i, full_a[k], n == DEP[k]); end
        checks++; if (empty_a[k] !== (n == 0)) begin errors++; $display("FAIL rand_empty inst%0d cyc%0d got %b exp %b", k, i, empty_a[k], n == 0); end
        checks++; if (ov_a[k] !== mov[k]) begin errors++; $display("FAIL rand_ovf inst%0d cyc%0d got %b exp %b", k, i, ov_a[k], mov[k]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; push = 1'b0; back = 1'b0; clr = 1'b0; din = '0;
    test_reset();
    test_fill();
    test_push_full();
    test_back();
    test_replace();
    test_clear_all();
    test_reset_mid();
    test_depth1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
